input_debounce_sync: RTL and testbench
======================================

// Module: input_debounce_sync
//
// PURPOSE
//  Front-end conditioning stage for the dedicated 8-bit input bus. Feeds the
//  pin-level output logic: everything downstream sees clean, glitch-free
//  levels instead of raw pad values.
//  Per bit: a 2-flop synchronizer, then a stability counter (debounce).
//  Also produces one-cycle rise/fall strobes and an aggregate "changed" strobe.
//
// PARAMETERS
//  WIDTH           8      number of input bits conditioned
//  DEBOUNCE_CYCLES 50000  cycles a synchronized level must hold before it is
//                         accepted; legal range 1..2^20
//
// PORTS
//  clk      in   1      system clock; all state on rising edge
//  rst_n    in   1      reset, asynchronous assert, active-low
//  ena      in   1      clock-enable; low = freeze all state
//  din      in   WIDTH  raw asynchronous pad inputs
//  dout     out  WIDTH  debounced, synchronous levels
//  rise     out  WIDTH  1-cycle strobe per bit: dout bit went 0->1
//  fall     out  WIDTH  1-cycle strobe per bit: dout bit went 1->0
//  changed  out  1      1-cycle strobe: OR of all rise|fall this cycle
//
// BEHAVIOUR
//  - Reset (rst_n=0, async): sync flops, counters, dout, rise, fall and
//    changed all clear to 0 immediately. Normal operation resumes on the
//    first rising edge with rst_n=1. Reset mid-count discards partial counts.
//  - Sync: s1 <= din; s2 <= s1. Only s2 is used downstream. din never reaches
//    the outputs combinationally.
//  - Counter per bit, width CW = $clog2(DEBOUNCE_CYCLES); minimum 1.
//  - Each enabled edge, per bit, the counter follows these rules:
//      s2 == dout                    : cnt <= 0.
//      s2 != dout, cnt <  N-1        : cnt <= cnt+1.
//      s2 != dout, cnt == N-1        : dout <= s2; cnt <= 0;
//                                      rise or fall asserted next cycle.
//    N = DEBOUNCE_CYCLES.
//  - Latency: din changes before edge E and stays stable. dout then updates
//    at edge E+N+1 (2 sync stages plus N compares).
//  - N=1 gives a pure synchronizer: dout updates at edge E+2.
//  - Glitch shorter than N sync'd cycles: counter returns to 0 and dout does
//    not change. A bounce resets the count; no hysteresis beyond that.
//  - Strobes: rise/fall/changed are registered and high for exactly one cycle
//    on the edge where dout flips. They are 0 on every other cycle.
//  - rise and fall are never both set for the same bit.
//  - Multiple bits may flip on the same edge; changed is then a single
//    1-cycle pulse.
//  - ena=0: sync flops, counters and dout hold their values.
//    rise/fall/changed are forced to 0.
//  - ena=0 on the cycle a flip would occur: the flip is deferred to the
//    next enabled edge. No strobe is lost; it fires on that edge.
//  - Counter never exceeds N-1, so it cannot wrap.
//  - Bits are independent; no cross-bit state except changed.
//
// STRUCTURE
//  - Shared package tt_io_pkg: localparam IO_WIDTH = 8 (default WIDTH).
//  - Shared package tt_io_pkg: function clog2_min1(n), used for CW.
//  - Sub-module debounce_bit: one bit's s1/s2, counter, level and rise/fall.
//    Ports clk, rst_n, ena, d, q, rise, fall; parameter DEBOUNCE_CYCLES.
//  - Top: generate loop of WIDTH debounce_bit instances.
//  - Top also holds the changed register:
//    changed <= ena & |(rise_next|fall_next).
//
// TESTING  (DEBOUNCE_CYCLES=4, WIDTH=8 unless stated)
//  1 Reset: rst_n=0 mid-cycle with din=FF
//    -> dout=00, rise=fall=00, changed=0 without a clock edge.
//  2 Clean step: din 00->01 before edge 0, held
//    -> dout=01 at edge 5; rise=01 and changed=1 for exactly cycle 5-6;
//       rise=00 afterwards.
//  3 Glitch: din bit0 high for 3 cycles then low
//    -> dout stays 00; rise, fall and changed never assert.
//  4 Multi-bit: din 01->A0 held
//    -> at edge E+5 dout=A0, rise=A0, fall=01, and one changed pulse.
//  5 ena gating: din 00->FF, ena=0 on edges 3..8
//    -> dout flips at edge 11 with rise=FF once; no strobes while ena=0.
//  6 N=1 build: din 00->3C before edge 0
//    -> dout=3C at edge 2, rise=3C one cycle.
//    Then assert rst_n mid-stream -> everything returns to 0.

Source files
------------

// File: rtl/tt_io_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tt_io_pkg
//  Description : Shared constants and helpers for the dedicated input bus
//                conditioning logic.
//  Revision    : 1.0 - initial release
// ============================================================================
package tt_io_pkg;

    // Width of the dedicated input bus.
    localparam int unsigned IO_WIDTH = 8;

    // Number of bits needed to hold 0..n-1, never less than one bit so a
    // pure-synchronizer build (n=1) still has a legal counter vector.
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned v;
        int unsigned r;
        v = (n > 0) ? n - 1 : 0;
        r = 0;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_bit.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_bit
//  Description : One input bit: two-flop synchronizer, stability counter,
//                debounced level and registered rise/fall strobes. The
//                combinational next-strobe values are exported so the parent
//                can register an aggregate strobe aligned with rise/fall.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_bit
    import tt_io_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic rise_next,
    output logic fall_next
);

    localparam int unsigned              c_cnt_w    = clog2_min1(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]       c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_s1;
    logic               r_s2;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_q;
    logic               r_rise;
    logic               r_fall;

    logic               w_differ;
    logic               w_flip;

    // The synchronized level disagrees with the accepted level; once it has
    // done so for the full window the level is accepted on this edge.
    always_comb begin
        w_differ  = r_s2 ^ r_q;
        w_flip    = w_differ && (r_cnt == c_cnt_last);
        rise_next = ena & w_flip & r_s2;
        fall_next = ena & w_flip & ~r_s2;
    end

    // Synchronizer, stability counter, accepted level and one-cycle strobes.
    // With ena low everything holds except the strobes, which drop to 0; a
    // pending flip simply happens on the next enabled edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_cnt  <= '0;
            r_q    <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_rise <= rise_next;
            r_fall <= fall_next;
            if (ena) begin
                r_s1 <= d;
                r_s2 <= r_s1;
                if (!w_differ) begin
                    r_cnt <= '0;
                end else if (w_flip) begin
                    r_q   <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign q    = r_q;
    assign rise = r_rise;
    assign fall = r_fall;

endmodule
`default_nettype wire

// File: rtl/input_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : input_debounce_sync
//  Description : Conditions the raw asynchronous input pads into clean,
//                debounced synchronous levels with per-bit rise/fall strobes
//                and an aggregate one-cycle "changed" strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module input_debounce_sync
    import tt_io_pkg::*;
#(
    parameter int unsigned WIDTH           = IO_WIDTH,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] w_rise_next;
    logic [WIDTH-1:0] w_fall_next;
    logic             r_changed;

    // Bits are fully independent; each gets its own conditioning slice.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce_bit (
            .clk       (clk),
            .rst_n     (rst_n),
            .ena       (ena),
            .d         (din[i]),
            .q         (dout[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .rise_next (w_rise_next[i]),
            .fall_next (w_fall_next[i])
        );
    end

    // Aggregate strobe registered from the per-bit next values so it lines
    // up with rise/fall; several bits flipping together give a single pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_changed <= 1'b0;
        end else begin
            r_changed <= ena & (|(w_rise_next | w_fall_next));
        end
    end

    assign changed = r_changed;

endmodule
`default_nettype wire

// File: tb/tb_input_debounce_sync.sv
`default_nettype none
// ============================================================================
//  Module      : tb_input_debounce_sync
//  Description : Self-checking bench for input_debounce_sync: directed
//                scenarios plus randomized pad activity compared against a
//                window-based behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce_sync;

    localparam int unsigned c_n = 4;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b1;
    logic [7:0] din   = 8'h00;
    logic [7:0] dout, rise, fall;
    logic       changed;
    logic [7:0] din1  = 8'h00;
    logic [7:0] dout1, rise1, fall1;
    logic       changed1;

    int n_pass  = 0;
    int n_total = 0;

    input_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(c_n)) u_dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din),
        .dout(dout), .rise(rise), .fall(fall), .changed(changed)
    );

    input_debounce_sync #(.WIDTH(8), .DEBOUNCE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din1),
        .dout(dout1), .rise(rise1), .fall(fall1), .changed(changed1)
    );

    always #5 clk = ~clk;

    // Behavioural model: a bit flips on an enabled edge when the last N
    // synchronized samples (enabled edges only) all disagree with the
    // accepted level and no flip of that bit happened inside that window.
    logic [7:0] m_s1 = '0, m_s2 = '0, m_dout = '0, m_rise = '0, m_fall = '0;
    logic       m_changed = 1'b0;
    logic [7:0] m_hist[$];
    int         m_k = 0;
    int         m_last[8];
    logic [7:0] m_nxt;
    bit         m_all;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_dout = '0;
            m_rise = '0; m_fall = '0; m_changed = 1'b0;
            m_hist.delete();
            m_k = 0;
            for (int b = 0; b < 8; b++) m_last[b] = -1;
        end else if (!ena) begin
            m_rise = '0; m_fall = '0; m_changed = 1'b0;
        end else begin
            m_hist.push_back(m_s2);
            if (m_hist.size() > c_n) void'(m_hist.pop_front());
            m_nxt = m_dout;
            for (int b = 0; b < 8; b++) begin
                if (m_hist.size() == c_n && (m_k - m_last[b]) >= int'(c_n)) begin
                    m_all = 1'b1;
                    for (int i = 0; i < m_hist.size(); i++)
                        if (m_hist[i][b] == m_dout[b]) m_all = 1'b0;
                    if (m_all) begin
                        m_nxt[b]  = ~m_dout[b];
                        m_last[b] = m_k;
                    end
                end
            end
            m_rise    = m_nxt & ~m_dout;
            m_fall    = ~m_nxt & m_dout;
            m_changed = |(m_rise | m_fall);
            m_dout    = m_nxt;
            m_s2      = m_s1;
            m_s1      = din;
            m_k       = m_k + 1;
        end
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance n cycles, comparing the N=4 instance with the model each cycle.
    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("model_dout", dout, m_dout);
            chk("model_rise", rise, m_rise);
            chk("model_fall", fall, m_fall);
            chk("model_changed", {7'd0, changed}, {7'd0, m_changed});
        end
    endtask

    initial begin
        // Power-up reset
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("reset_dout", dout, 8'h00);
        chk("reset_rise", rise, 8'h00);
        chk("reset_fall", fall, 8'h00);
        chk("reset_dout1", dout1, 8'h00);

        // 1: async reset mid-cycle with din=FF
        din = 8'hFF;
        tick(8);
        chk("t1_pre_dout", dout, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_dout", dout, 8'h00);
        chk("t1_rise", rise, 8'h00);
        chk("t1_fall", fall, 8'h00);
        chk("t1_changed", {7'd0, changed}, 8'h00);
        tick(1);
        din   = 8'h00;
        rst_n = 1'b1;

        // 2: clean step, flip at edge 5
        din = 8'h01;
        tick(5);
        chk("t2_dout_e4", dout, 8'h00);
        tick(1);
        chk("t2_dout_e5", dout, 8'h01);
        chk("t2_rise_e5", rise, 8'h01);
        chk("t2_fall_e5", fall, 8'h00);
        chk("t2_changed_e5", {7'd0, changed}, 8'h01);
        tick(1);
        chk("t2_rise_e6", rise, 8'h00);
        chk("t2_changed_e6", {7'd0, changed}, 8'h00);
        chk("t2_dout_e6", dout, 8'h01);

        // 3: glitch of 3 cycles is rejected
        din = 8'h00;
        tick(8);
        chk("t3_base", dout, 8'h00);
        din = 8'h01;
        tick(3);
        din = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("t3_dout", dout, 8'h00);
            chk("t3_strobes", rise | fall, 8'h00);
            chk("t3_changed", {7'd0, changed}, 8'h00);
        end

        // 4: multi-bit change 01 -> A0
        din = 8'h01;
        tick(8);
        chk("t4_base", dout, 8'h01);
        din = 8'hA0;
        tick(5);
        chk("t4_dout_e4", dout, 8'h01);
        tick(1);
        chk("t4_dout", dout, 8'hA0);
        chk("t4_rise", rise, 8'hA0);
        chk("t4_fall", fall, 8'h01);
        chk("t4_changed", {7'd0, changed}, 8'h01);
        tick(1);
        chk("t4_changed_after", {7'd0, changed}, 8'h00);
        chk("t4_strobes_after", rise | fall, 8'h00);

        // 5: ena low on edges 3..8 defers the flip to edge 11
        din = 8'h00;
        tick(8);
        chk("t5_base", dout, 8'h00);
        din = 8'hFF;
        tick(3);
        ena = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            chk("t5_gated_dout", dout, 8'h00);
            chk("t5_gated_strobes", rise | fall, 8'h00);
            chk("t5_gated_changed", {7'd0, changed}, 8'h00);
        end
        ena = 1'b1;
        tick(2);
        chk("t5_dout_e10", dout, 8'h00);
        tick(1);
        chk("t5_dout_e11", dout, 8'hFF);
        chk("t5_rise_e11", rise, 8'hFF);
        chk("t5_changed_e11", {7'd0, changed}, 8'h01);
        tick(1);
        chk("t5_rise_e12", rise, 8'h00);
        chk("t5_changed_e12", {7'd0, changed}, 8'h00);

        // 6: N=1 instance is a pure synchronizer
        din1 = 8'h3C;
        tick(1);
        chk("t6_dout1_e0", dout1, 8'h00);
        tick(1);
        chk("t6_dout1_e1", dout1, 8'h00);
        tick(1);
        chk("t6_dout1_e2", dout1, 8'h3C);
        chk("t6_rise1_e2", rise1, 8'h3C);
        chk("t6_fall1_e2", fall1, 8'h00);
        chk("t6_changed1_e2", {7'd0, changed1}, 8'h01);
        tick(1);
        chk("t6_rise1_e3", rise1, 8'h00);
        chk("t6_changed1_e3", {7'd0, changed1}, 8'h00);
        chk("t6_dout1_e3", dout1, 8'h3C);
        din1 = 8'hC3;
        tick(1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_dout1", dout1, 8'h00);
        chk("t6_rst_rise1", rise1 | fall1, 8'h00);
        chk("t6_rst_changed1", {7'd0, changed1}, 8'h00);
        chk("t6_rst_dout", dout, 8'h00);
        tick(1);
        din  = 8'h00;
        din1 = 8'h00;
        rst_n = 1'b1;

        // Randomized pad activity with occasional clock-enable gaps
        for (int seg = 0; seg < 120; seg++) begin
            int len;
            if ($urandom_range(0, 2) == 0) din = din ^ (8'h01 << $urandom_range(0, 7));
            else din = 8'($urandom);
            len = $urandom_range(1, 9);
            repeat (len) begin
                ena = ($urandom_range(0, 6) != 0);
                tick(1);
            end
        end
        ena = 1'b1;
        tick(10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
